// File: rtl/jtag_user_if.sv
// JTAG DR-side signals between a BSCANE2-style USER primitive and the user logic.
// master = BSCAN / host side, slave = user logic side.
interface jtag_user_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic ir_is_user;
    logic run_test_idle;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;

    modport master (
        output tms, tdi, ir_is_user, run_test_idle, capture_dr, shift_dr, update_dr,
        input  tdo
    );

    modport slave (
        input  tms, tdi, ir_is_user, run_test_idle, capture_dr, shift_dr, update_dr,
        output tdo
    );
endinterface

// File: rtl/jtag_user_logic.sv
// Houses-visited solver behind a USER JTAG chain: deserializes move bytes from TDI,
// marks visited cells in a bitmap and returns the distinct-cell count on TDO.
module jtag_user_logic #(
    parameter int COORD_WIDTH  = 8,
    parameter int RESULT_WIDTH = 32
) (
    input  logic        tck,
    input  logic        test_logic_reset,
    jtag_user_if.slave  jtag
);

    localparam int AW = 2 * COORD_WIDTH;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic signed [COORD_WIDTH-1:0] C_ONE   = {{(COORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RESULT_WIDTH-1:0]       CNT_ONE = {{(RESULT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]                 ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic cap;
    logic sh;
    logic upd;

    assign cap = jtag.capture_dr & jtag.ir_is_user;
    assign sh  = jtag.shift_dr   & jtag.ir_is_user;
    assign upd = jtag.update_dr  & jtag.ir_is_user;

    // Update-DR is reserved; TMS and Run-Test/Idle carry no function here.
    logic unused_inputs;
    assign unused_inputs = ^{jtag.tms, jtag.run_test_idle, upd};

    logic [2:0]                     bit_cnt;
    logic [7:0]                     shift_byte;
    logic                           byte_vld_p0;
    logic [1:0]                     state;
    logic [AW-1:0]                  clr_addr;
    logic                           clr_last;
    logic signed [COORD_WIDTH-1:0]  pos_x;
    logic signed [COORD_WIDTH-1:0]  pos_y;
    logic signed [COORD_WIDTH-1:0]  next_x;
    logic signed [COORD_WIDTH-1:0]  next_y;
    logic                           mv_vld;
    logic [RESULT_WIDTH-1:0]        count;
    logic                           rd_bit_p1;
    logic [RESULT_WIDTH-1:0]        out_sr;
    logic                           tdo_r;
    logic                           mem_we;
    logic [AW-1:0]                  mem_addr;
    logic                           mem_wdata;
    logic [AW-1:0]                  pos_addr;
    logic                           bitmap [0:(1 << AW) - 1];

    assign pos_addr = {pos_y, pos_x};

    // Stage p0: LSB-first byte deserializer; a partial byte is dropped at the next capture.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            bit_cnt     <= 3'd0;
            shift_byte  <= 8'd0;
            byte_vld_p0 <= 1'b0;
        end else begin
            byte_vld_p0 <= 1'b0;
            if (cap) begin
                bit_cnt <= 3'd0;
            end else if (sh) begin
                shift_byte  <= {jtag.tdi, shift_byte[7:1]};
                bit_cnt     <= bit_cnt + 3'd1;
                byte_vld_p0 <= (bit_cnt == 3'd7);
            end
        end
    end

    always_comb begin
        mv_vld = 1'b1;
        next_x = pos_x;
        next_y = pos_y;
        case (shift_byte)
            8'h5E:   next_y = pos_y + C_ONE;
            8'h76:   next_y = pos_y - C_ONE;
            8'h3E:   next_x = pos_x + C_ONE;
            8'h3C:   next_x = pos_x - C_ONE;
            default: mv_vld = 1'b0;
        endcase
    end

    // Stage p1/p2: clear sweep, then read-modify-write of the visited bit per move.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            clr_last <= 1'b0;
            pos_x    <= '0;
            pos_y    <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_last) begin
                        clr_last <= 1'b0;
                        count    <= CNT_ONE;
                        state    <= ST_IDLE;
                    end else begin
                        clr_addr <= clr_addr + ADR_ONE;
                        if (&clr_addr)
                            clr_last <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (byte_vld_p0 && mv_vld) begin
                        pos_x <= next_x;
                        pos_y <= next_y;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_WRITE;
                end
                default: begin
                    if (!rd_bit_p1 && !(&count))
                        count <= count + CNT_ONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = pos_addr;
        mem_wdata = 1'b1;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_last ? '0 : clr_addr;
            mem_wdata = clr_last;
        end else if (state == ST_WRITE) begin
            mem_we = !rd_bit_p1;
        end
    end

    always_ff @(posedge tck) begin
        if (mem_we)
            bitmap[mem_addr] <= mem_wdata;
        if (state == ST_READ)
            rd_bit_p1 <= bitmap[pos_addr];
    end

    // Readout: count captured at Capture-DR, shifted out LSB first with zero fill.
    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            out_sr <= '0;
            tdo_r  <= 1'b0;
        end else if (!jtag.ir_is_user) begin
            tdo_r <= 1'b0;
        end else if (cap) begin
            out_sr <= count;
        end else if (sh) begin
            tdo_r  <= out_sr[0];
            out_sr <= {1'b0, out_sr[RESULT_WIDTH-1:1]};
        end
    end

    assign jtag.tdo = tdo_r;

endmodule

// File: tb/tb_jtag_user_logic.sv
// Bench for jtag_user_logic: directed puzzle uploads plus randomized move streams
// checked against a set-of-visited-cells reference model.
module tb_jtag_user_logic;

    localparam int CW    = 4;
    localparam int NCELL = 1 << (2 * CW);
    localparam int CMASK = (1 << CW) - 1;

    logic tck = 1'b0;
    logic rst;

    jtag_user_if jif();

    always #5 tck = ~tck;

    jtag_user_logic #(.COORD_WIDTH(CW), .RESULT_WIDTH(32)) dut (
        .tck              (tck),
        .test_logic_reset (rst),
        .jtag             (jif.slave)
    );

    int          total = 0;
    int          bad   = 0;
    bit          scan_q[$];
    int          mx;
    int          my;
    bit          vis[int];
    int unsigned mcount;
    bit          model_on;

    function automatic void model_reset();
        vis.delete();
        mx = 0;
        my = 0;
        vis[0] = 1'b1;
        mcount = 1;
    endfunction

    function automatic void model_byte(input logic [7:0] c);
        bit moved;
        int key;
        moved = 1'b1;
        case (c)
            8'h5E:   my = (my + 1) & CMASK;
            8'h76:   my = (my - 1) & CMASK;
            8'h3E:   mx = (mx + 1) & CMASK;
            8'h3C:   mx = (mx - 1) & CMASK;
            default: moved = 1'b0;
        endcase
        key = my * (1 << CW) + mx;
        if (moved && !vis.exists(key)) begin
            vis[key] = 1'b1;
            mcount++;
        end
    endfunction

    task automatic add_byte(input logic [7:0] c);
        for (int i = 0; i < 8; i++) scan_q.push_back(c[i]);
        if (model_on) model_byte(c);
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) add_byte(s[i]);
    endtask

    task automatic add_bits(input int n);
        for (int i = 0; i < n; i++) scan_q.push_back(1'($urandom_range(1, 0)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tck);
    endtask

    // One DR scan of scan_q; first 32 tdo bits returned. abort_at>=0 asserts reset at that bit.
    task automatic scan(output logic [31:0] rd, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        rd = '0;
        @(negedge tck);
        jif.capture_dr = 1'b1;
        @(negedge tck);
        jif.capture_dr = 1'b0;
        jif.shift_dr   = 1'b1;
        for (int i = 0; i < scan_q.size(); i++) begin
            if (i == abort_at) begin
                #2 rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            jif.tdi = scan_q[i];
            @(posedge tck);
            #1;
            if (i < 32) rd[i] = jif.tdo;
            @(negedge tck);
        end
        jif.shift_dr = 1'b0;
        jif.tdi      = 1'b0;
        if (!aborted) begin
            jif.update_dr = 1'b1;
            @(negedge tck);
            jif.update_dr = 1'b0;
            idle(4);
        end
        scan_q.delete();
    endtask

    task automatic readout(output logic [31:0] rd);
        for (int i = 0; i < 32; i++) scan_q.push_back(1'b0);
        scan(rd, -1);
    endtask

    task automatic do_reset();
        @(negedge tck);
        #1 rst = 1'b1;
        #1;
        total++;
        if (jif.tdo !== 1'b0) begin
            bad++;
            $display("FAIL reset_tdo: got %b expected 0", jif.tdo);
        end
        idle(3);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_clear();
        jif.run_test_idle = 1'b1;
        idle(NCELL + 12);
        jif.run_test_idle = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        readout(rd);
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("FAIL count_during_clear: got %0d expected 0", rd);
        end
        wait_clear();
        readout(rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("FAIL count_after_clear: got %0d expected 1", rd);
        end
    endtask

    task automatic test_directed(input string s, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        do_reset();
        wait_clear();
        add_str(s);
        scan(rd, -1);
        readout(rd);
        total++;
        if (rd !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, rd, exp);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd;
        do_reset();
        wait_clear();
        add_bits(3);
        scan(rd, -1);
        add_str("^>");
        scan(rd, -1);
        readout(rd);
        total++;
        if (rd !== 32'd3) begin
            bad++;
            $display("FAIL partial_discard: got %0d expected 3", rd);
        end
    endtask

    task automatic test_ir_gate();
        logic [31:0] rd;
        do_reset();
        wait_clear();
        jif.ir_is_user = 1'b0;
        model_on = 1'b0;
        add_str(">");
        for (int i = 0; i < 4; i++) add_byte(8'h00);
        scan(rd, -1);
        model_on = 1'b1;
        jif.ir_is_user = 1'b1;
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("FAIL ir_gate_tdo: got %h expected 0", rd);
        end
        readout(rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("FAIL ir_gate_count: got %0d expected 1", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_reset();
        wait_clear();
        add_str("^>v<");
        scan(rd, 20);
        #1;
        total++;
        if (jif.tdo !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_tdo: got %b expected 0", jif.tdo);
        end
        idle(3);
        rst = 1'b0;
        model_reset();
        wait_clear();
        readout(rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("FAIL mid_reset_count: got %0d expected 1", rd);
        end
        add_str(">>");
        scan(rd, -1);
        readout(rd);
        total++;
        if (rd !== 32'd3) begin
            bad++;
            $display("FAIL mid_reset_reupload: got %0d expected 3", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        string       tbl;
        int unsigned prev;
        int          n;
        tbl = "^v<>\n a";
        do_reset();
        wait_clear();
        for (int r = 0; r < 6; r++) begin
            prev = mcount;
            if (r == 0) begin
                for (int k = 0; k < 20; k++) add_byte(8'h3E);
            end else begin
                n = int'($urandom_range(40, 5));
                for (int k = 0; k < n; k++) add_byte(tbl[int'($urandom_range(6, 0))]);
            end
            add_bits(int'($urandom_range(7, 0)));
            if (scan_q.size() >= 32) begin
                scan(rd, -1);
                total++;
                if (rd !== prev) begin
                    bad++;
                    $display("FAIL random_inscan_rd r=%0d: got %0d expected %0d", r, rd, prev);
                end
            end else begin
                scan(rd, -1);
            end
            readout(rd);
            total++;
            if (rd !== mcount) begin
                bad++;
                $display("FAIL random_count r=%0d: got %0d expected %0d", r, rd, mcount);
            end
        end
    endtask

    initial begin
        rst               = 1'b0;
        jif.tms           = 1'b0;
        jif.tdi           = 1'b0;
        jif.ir_is_user    = 1'b1;
        jif.run_test_idle = 1'b0;
        jif.capture_dr    = 1'b0;
        jif.shift_dr      = 1'b0;
        jif.update_dr     = 1'b0;
        model_on          = 1'b1;
        model_reset();

        test_reset();
        test_directed(">", 32'd2, "single_move");
        test_directed("^>v<", 32'd4, "loop_back_origin");
        test_directed("^v^v^v^v^v\n", 32'd2, "bounce_with_lf");
        test_partial();
        test_ir_gate();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
